// File: rtl/nco_clken_synth.sv
// rtl/nco_clken_synth.sv - multi-channel NCO clock-enable synthesiser with settle/lock indication
module nco_clken_synth #(
  parameter int CHANNELS      = 2,
  parameter int ACC_W         = 32,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [CHANNELS*ACC_W-1:0] freq_word,
  input  logic [CHANNELS*ACC_W-1:0] phase_word,
  output logic [CHANNELS-1:0]       outclk_en,
  output logic [CHANNELS-1:0]       outclk_sq,
  output logic                      locked
);

  // Counter only needs to reach SETTLE_CYCLES-1, so clog2(SETTLE_CYCLES) bits suffice.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] sq_q, sq_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic                locked_q, locked_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ACC_W-1:0] freq_q, freq_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    // Per-channel next state: load reprograms, enable advances, otherwise hold with no pulse.
    always_comb begin
      freq_d  = freq_q;
      acc_d   = acc_q;
      en_d[c] = 1'b0;
      sq_d[c] = sq_q[c];
      sum     = {1'b0, acc_q} + {1'b0, freq_q};
      if (load) begin
        freq_d  = freq_word[c*ACC_W +: ACC_W];
        acc_d   = phase_word[c*ACC_W +: ACC_W];
        sq_d[c] = phase_word[c*ACC_W + ACC_W - 1];
      end else if (enable) begin
        acc_d   = sum[ACC_W-1:0];
        en_d[c] = sum[ACC_W];
        sq_d[c] = sum[ACC_W-1];
      end
    end

    // Per-channel shadow frequency and phase accumulator registers.
    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        freq_q <= '0;
        acc_q  <= '0;
      end else begin
        freq_q <= freq_d;
        acc_q  <= acc_d;
      end
    end
  end

  // Lock tracking: count up while unlocked, lock after reaching the last count; load restarts.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    locked_d     = locked_q;
    if (load) begin
      settle_cnt_d = '0;
      locked_d     = 1'b0;
    end else if (!locked_q) begin
      if (settle_cnt_q == CNT_LAST) begin
        locked_d = 1'b1;
      end else begin
        settle_cnt_d = settle_cnt_q + 1'b1;
      end
    end
  end

  // Registered outputs and settle state.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      en_q         <= '0;
      sq_q         <= '0;
      settle_cnt_q <= '0;
      locked_q     <= 1'b0;
    end else begin
      en_q         <= en_d;
      sq_q         <= sq_d;
      settle_cnt_q <= settle_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign outclk_en = en_q;
  assign outclk_sq = sq_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_nco_clken_synth.sv
// tb/tb_nco_clken_synth.sv - directed self-checking bench for nco_clken_synth
module tb_nco_clken_synth;

  logic        refclk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] freq_word;
  logic [15:0] phase_word;
  logic [1:0]  outclk_en;
  logic [1:0]  outclk_sq;
  logic        locked;

  int checks   = 0;
  int failures = 0;
  int pulses;
  logic prev_en;

  always #5 refclk = ~refclk;

  nco_clken_synth #(
    .CHANNELS(2),
    .ACC_W(8),
    .SETTLE_CYCLES(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .enable(enable),
    .load(load),
    .freq_word(freq_word),
    .phase_word(phase_word),
    .outclk_en(outclk_en),
    .outclk_sq(outclk_sq),
    .locked(locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    freq_word  = '0;
    phase_word = '0;
    #12;
    check("rst_en", 32'(outclk_en), 32'd0);
    check("rst_sq", 32'(outclk_sq), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);

    // ch0 freq=64 phase=0
    rst        = 1'b1;
    enable     = 1'b1;
    load       = 1'b1;
    freq_word  = {8'd0, 8'd64};
    phase_word = {8'd0, 8'd0};
    tick();
    load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("p1_en0", 32'(outclk_en[0]), 32'(k % 4 == 0));
      check("p1_sq0", 32'(outclk_sq[0]), 32'((k % 4 == 2) || (k % 4 == 3)));
      check("p1_en1", 32'(outclk_en[1]), 32'd0);
      check("p1_locked", 32'(locked), 32'(k >= 16));
    end

    // ch0 freq=64 phase=0, ch1 freq=64 phase=128
    load       = 1'b1;
    freq_word  = {8'd64, 8'd64};
    phase_word = {8'd128, 8'd0};
    tick();
    load = 1'b0;
    check("p2_locked_after_load", 32'(locked), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("p2_en0", 32'(outclk_en[0]), 32'(k % 4 == 0));
      check("p2_en1", 32'(outclk_en[1]), 32'(k % 4 == 2));
      check("p2_sq1", 32'(outclk_sq[1]), 32'((k % 4 == 1) || (k % 4 == 0)));
    end

    // ch0 freq=96, second load at edge 10 restarts lock count
    load       = 1'b1;
    freq_word  = {8'd0, 8'd96};
    phase_word = {8'd0, 8'd0};
    tick();
    load = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("p3_locked_pre", 32'(locked), 32'd0);
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    check("p3_en_second_load", 32'(outclk_en), 32'd0);
    pulses  = 0;
    prev_en = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      check("p3_en0", 32'(outclk_en[0]), 32'((k % 8 == 3) || (k % 8 == 6) || (k % 8 == 0)));
      check("p3_adjacent", 32'(outclk_en[0] & prev_en), 32'd0);
      check("p3_locked", 32'(locked), 32'(k >= 16));
      pulses  = pulses + int'(outclk_en[0]);
      prev_en = outclk_en[0];
    end
    check("p3_pulse_count", 32'(pulses), 32'd24);

    // enable drop for 5 cycles, schedule shifts by 5
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("p4_en0_pre", 32'(outclk_en[0]), 32'(k == 3));
    end
    enable = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("p4_en0_hold", 32'(outclk_en[0]), 32'd0);
      check("p4_sq0_hold", 32'(outclk_sq[0]), 32'd1);
    end
    enable = 1'b1;
    for (int j = 5; j <= 18; j++) begin
      tick();
      check("p4_en0_resume", 32'(outclk_en[0]), 32'((j % 8 == 3) || (j % 8 == 6) || (j % 8 == 0)));
      check("p4_sq0_resume", 32'(outclk_sq[0]), 32'(((96 * j) % 256) >= 128));
    end

    // load with enable high on an edge that would otherwise carry
    load       = 1'b1;
    freq_word  = {8'd0, 8'd96};
    phase_word = {8'd0, 8'd200};
    tick();
    load = 1'b0;
    check("p5_en0_load", 32'(outclk_en[0]), 32'd0);
    check("p5_sq0_load", 32'(outclk_sq[0]), 32'd1);
    tick();
    check("p5_en0_next", 32'(outclk_en[0]), 32'd1);
    check("p5_sq0_next", 32'(outclk_sq[0]), 32'd0);
    tick();
    check("p5_sq0_run", 32'(outclk_sq[0]), 32'd1);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    check("p6_async_en", 32'(outclk_en), 32'd0);
    check("p6_async_sq", 32'(outclk_sq), 32'd0);
    check("p6_async_locked", 32'(locked), 32'd0);
    freq_word  = '0;
    phase_word = '0;
    enable     = 1'b1;
    #3;
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("p6_en", 32'(outclk_en), 32'd0);
      check("p6_sq", 32'(outclk_sq), 32'd0);
      check("p6_locked", 32'(locked), 32'(k >= 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
